lcd_char_ctrl: RTL and testbench
================================

LCD_CHAR_CTRL -- requirements
Module: lcd_char_ctrl

Interface
REQ-001 SHALL have parameter E_CYC, default 12, meaning enable-high width in clocks (240 ns at 50 MHz).
REQ-002 SHALL have parameter CMD_CYC, default 2500, meaning post-command/post-char wait in clocks (50 us).
REQ-003 SHALL have parameter CLR_CYC, default 100000, meaning post-clear wait in clocks (2 ms).
REQ-004 SHALL have parameter PWR_CYC, default 1000000, meaning power-up wait in clocks (20 ms).
REQ-005 clkFSM  in  1  sole clock; all state changes on rising edge.
REQ-006 resetFSM  in  1  asynchronous, active-low reset (low = reset).
REQ-007 data  in  8  ASCII character to write, sampled with writeStart.
REQ-008 writeStart  in  1  single-cycle write request.
REQ-009 initDone  out  1  high once LCD init completes; stays high until reset.
REQ-010 writeDone  out  1  single-cycle pulse: character write finished.
REQ-011 lcd_data  out  8  HD44780 DB7..DB0.
REQ-012 lcd_rs  out  1  0 = command, 1 = character data.
REQ-013 lcd_rw  out  1  tied 0 (write only).
REQ-014 lcd_e  out  1  HD44780 enable strobe.

Function
REQ-015 States SHALL be: PWR_WAIT, CMD_SETUP, CMD_E, CMD_WAIT, READY, WR_SETUP, WR_E, WR_WAIT, ADDR_SETUP, ADDR_E, ADDR_WAIT, DONE.
REQ-016 PWR_WAIT SHALL hold PWR_CYC clocks, then enter the init command sequence.
REQ-017 Init sequence SHALL issue, in order, with lcd_rs=0: 0x38, 0x0C, 0x01, 0x06.
REQ-018 Each command SHALL take: 1 SETUP clock (lcd_data/lcd_rs valid, lcd_e=0), E_CYC clocks lcd_e=1, then wait CMD_CYC clocks (CLR_CYC after 0x01), lcd_e=0.
REQ-019 After the wait of 0x06, initDone SHALL rise and state SHALL enter READY.
REQ-020 writeStart SHALL be accepted only in READY with initDone=1; ignored in all other states (no queuing).
REQ-021 On acceptance (cycle 0), data SHALL be latched; WR_SETUP at cycle 1 drives lcd_rs=1, lcd_data=latched value.
REQ-022 lcd_e SHALL be high cycles 2..E_CYC+1; lcd_data/lcd_rs SHALL hold stable from cycle 1 through the wait.
REQ-023 After CMD_CYC wait clocks, writeDone SHALL pulse for exactly one clock (DONE), then return to READY; no-wrap latency = E_CYC+CMD_CYC+2 clocks.
REQ-024 A 5-bit cursor position SHALL increment per character written (0..31).
REQ-025 Position 15->16 SHALL insert an address command 0xC0 (line 2) before writeDone; 31->0 SHALL insert 0x80 (line 1), same timing as REQ-018.
REQ-026 lcd_rw SHALL be 0 at all times; lcd_e SHALL never be high in SETUP or WAIT states.
REQ-027 Wait counter SHALL be wide enough for max(PWR_CYC, CLR_CYC) and reload on each state entry.

Reset
REQ-028 resetFSM low SHALL asynchronously force PWR_WAIT, counters 0, position 0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, initDone=0, writeDone=0.
REQ-029 Reset asserted mid-write or mid-init SHALL abort immediately; after release the full power-up and init sequence SHALL repeat.

Structure
REQ-030 Shared package SHALL hold state encodings, init command values (0x38, 0x0C, 0x01, 0x06), and line addresses (0x80, 0xC0).
REQ-031 One sub-module lcd_strobe (setup/enable/wait sequencer with done pulse) SHALL be shared by init, char and address writes.

Verification (parameters E_CYC=2, CMD_CYC=4, CLR_CYC=8, PWR_CYC=10)
REQ-032 Reset release -> 10 idle clocks, then lcd_data 0x38,0x0C,0x01,0x06 each with 2-clock lcd_e pulse, rs=0; initDone rises after the 0x06 wait.
REQ-033 writeStart with data=0x41 in READY -> lcd_rs=1, lcd_data=0x41, lcd_e high 2 clocks, writeDone pulse exactly 8 clocks after acceptance.
REQ-034 16 consecutive writes -> 16th followed by command 0xC0 before its writeDone; 32nd followed by 0x80.
REQ-035 writeStart pulsed before initDone and during WR_WAIT -> ignored, no lcd_e pulse, no writeDone.
REQ-036 resetFSM low during WR_E -> lcd_e=0, initDone=0 immediately; after release full init repeats.

Source files
------------

// File: rtl/lcd_char_ctrl_pkg.sv
// Shared definitions for the HD44780 character controller: FSM encodings,
// the power-up command list and the DDRAM line addresses.
package lcd_char_ctrl_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        CMD_SETUP,
        CMD_E,
        CMD_WAIT,
        READY,
        WR_SETUP,
        WR_E,
        WR_WAIT,
        ADDR_SETUP,
        ADDR_E,
        ADDR_WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ENABLE,
        PH_HOLD
    } phase_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] ADDR_LINE1   = 8'h80;
    localparam logic [7:0] ADDR_LINE2   = 8'hC0;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_strobe.sv
// Setup / enable / hold sequencer for one HD44780 bus write; the bus value is
// captured on start and held until the next start, done pulses in the last hold clock.
module lcd_strobe
    import lcd_char_ctrl_pkg::*;
#(
    parameter int E_CYC = 12,
    parameter int CW    = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    cmd_byte,
    input  logic          rs,
    input  logic [CW-1:0] hold_cyc,
    output logic [7:0]    lcd_data,
    output logic          lcd_rs,
    output logic          lcd_e,
    output logic          e_last,
    output logic          done
);

    localparam logic [CW-1:0] E_LAST = CW'(E_CYC - 1);

    phase_t        phase;
    phase_t        phase_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hold_len;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        phase_next = phase;
        e_last     = (phase == PH_ENABLE) && (cnt == E_LAST);
        done       = (phase == PH_HOLD) && (cnt == hold_len - CW'(1));
        case (phase)
            PH_IDLE:   if (start) phase_next = PH_SETUP;
            PH_SETUP:  phase_next = PH_ENABLE;
            PH_ENABLE: if (e_last) phase_next = PH_HOLD;
            PH_HOLD:   if (done) phase_next = start ? PH_SETUP : PH_IDLE;
            default:   phase_next = PH_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            hold_len <= '0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
        end else begin
            phase <= phase_next;
            // Counter restarts on every phase entry so each phase times itself from zero.
            if (phase_next != phase || phase == PH_IDLE) cnt <= '0;
            else                                         cnt <= cnt + CW'(1);
            if (start) begin
                lcd_data <= cmd_byte;
                lcd_rs   <= rs;
                hold_len <= hold_cyc;
            end
            lcd_e <= (phase_next == PH_ENABLE);
        end
    end

endmodule

// File: rtl/lcd_char_ctrl.sv
// HD44780 character controller: power-up wait, four-command init, then single
// character writes with automatic line-2 / line-1 cursor moves every 16 characters.
module lcd_char_ctrl
    import lcd_char_ctrl_pkg::*;
#(
    parameter int E_CYC   = 12,
    parameter int CMD_CYC = 2500,
    parameter int CLR_CYC = 100000,
    parameter int PWR_CYC = 1000000
) (
    input  logic       clkFSM,
    input  logic       resetFSM,
    input  logic [7:0] data,
    input  logic       writeStart,
    output logic       initDone,
    output logic       writeDone,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam int            CW       = cnt_width(PWR_CYC, CLR_CYC, CMD_CYC, E_CYC);
    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_CYC - 1);
    localparam logic [CW-1:0] CMD_LEN  = CW'(CMD_CYC);
    localparam logic [CW-1:0] CLR_LEN  = CW'(CLR_CYC);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] pwr_cnt;
    logic [1:0]    cmd_idx;
    logic [4:0]    pos;

    logic          st_start;
    logic [7:0]    st_byte;
    logic          st_rs;
    logic [CW-1:0] st_hold;
    logic          st_e_last;
    logic          st_done;

    always_comb begin
        state_next = state;
        st_start   = 1'b0;
        st_byte    = 8'h00;
        st_rs      = 1'b0;
        case (state)
            PWR_WAIT: if (pwr_cnt == PWR_LAST) begin
                state_next = CMD_SETUP;
                st_start   = 1'b1;
                st_byte    = init_cmd(2'd0);
            end
            CMD_SETUP: state_next = CMD_E;
            CMD_E:     if (st_e_last) state_next = CMD_WAIT;
            CMD_WAIT:  if (st_done) begin
                if (cmd_idx == 2'd3) begin
                    state_next = READY;
                end else begin
                    state_next = CMD_SETUP;
                    st_start   = 1'b1;
                    st_byte    = init_cmd(cmd_idx + 2'd1);
                end
            end
            READY: if (writeStart && initDone) begin
                state_next = WR_SETUP;
                st_start   = 1'b1;
                st_byte    = data;
                st_rs      = 1'b1;
            end
            WR_SETUP: state_next = WR_E;
            WR_E:     if (st_e_last) state_next = WR_WAIT;
            WR_WAIT:  if (st_done) begin
                // Cursor leaves the end of a 16-character line: move to the other line.
                if (pos == 5'd15 || pos == 5'd31) begin
                    state_next = ADDR_SETUP;
                    st_start   = 1'b1;
                    st_byte    = (pos == 5'd15) ? ADDR_LINE2 : ADDR_LINE1;
                end else begin
                    state_next = DONE;
                end
            end
            ADDR_SETUP: state_next = ADDR_E;
            ADDR_E:     if (st_e_last) state_next = ADDR_WAIT;
            ADDR_WAIT:  if (st_done) state_next = DONE;
            DONE:       state_next = READY;
            default:    state_next = PWR_WAIT;
        endcase
        st_hold = (!st_rs && st_byte == CMD_CLEAR) ? CLR_LEN : CMD_LEN;
    end

    always_ff @(posedge clkFSM or negedge resetFSM) begin
        if (!resetFSM) begin
            state     <= PWR_WAIT;
            pwr_cnt   <= '0;
            cmd_idx   <= 2'd0;
            pos       <= 5'd0;
            initDone  <= 1'b0;
            writeDone <= 1'b0;
        end else begin
            state <= state_next;
            if (state == PWR_WAIT && state_next == PWR_WAIT) pwr_cnt <= pwr_cnt + CW'(1);
            else                                             pwr_cnt <= '0;
            if (state == CMD_WAIT && st_done && cmd_idx != 2'd3) cmd_idx <= cmd_idx + 2'd1;
            if (state == WR_WAIT && st_done) pos <= pos + 5'd1;
            if (state == CMD_WAIT && state_next == READY) initDone <= 1'b1;
            writeDone <= (state_next == DONE);
        end
    end

    lcd_strobe #(
        .E_CYC (E_CYC),
        .CW    (CW)
    ) u_strobe (
        .clk      (clkFSM),
        .rst_n    (resetFSM),
        .start    (st_start),
        .cmd_byte (st_byte),
        .rs       (st_rs),
        .hold_cyc (st_hold),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .e_last   (st_e_last),
        .done     (st_done)
    );

    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench for lcd_char_ctrl with short timing parameters
// (E_CYC=2, CMD_CYC=4, CLR_CYC=8, PWR_CYC=10).
module tb_lcd_char_ctrl;

    logic       clkFSM = 1'b0;
    logic       resetFSM = 1'b1;
    logic [7:0] data = 8'h00;
    logic       writeStart = 1'b0;
    logic       initDone;
    logic       writeDone;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;

    int n_vec = 0;
    int n_err = 0;

    // Hand-derived init timeline, in clocks after reset release: setup clock of each command.
    localparam int         INIT_SETUP[4] = '{10, 17, 24, 35};
    localparam logic [7:0] INIT_BYTE[4]  = '{8'h38, 8'h0C, 8'h01, 8'h06};
    localparam int         INIT_HOLD[4]  = '{4, 4, 8, 4};

    lcd_char_ctrl #(
        .E_CYC   (2),
        .CMD_CYC (4),
        .CLR_CYC (8),
        .PWR_CYC (10)
    ) dut (
        .clkFSM     (clkFSM),
        .resetFSM   (resetFSM),
        .data       (data),
        .writeStart (writeStart),
        .initDone   (initDone),
        .writeDone  (writeDone),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e)
    );

    always #5 clkFSM = ~clkFSM;

    task automatic tick();
        @(posedge clkFSM);
        #1;
    endtask

    // One character write from READY; reports latency to writeDone and the enable pulses seen.
    task automatic do_write(input logic [7:0] ch, output int lat, output int n_pulse,
                            output logic [7:0] d0, output logic r0,
                            output logic [7:0] d1, output logic r1);
        logic prev_e;
        lat = -1; n_pulse = 0; d0 = 8'h00; r0 = 1'b0; d1 = 8'h00; r1 = 1'b0;
        prev_e = lcd_e;
        data = ch;
        writeStart = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            writeStart = 1'b0;
            if (lcd_e && !prev_e) begin
                if (n_pulse == 0) begin d0 = lcd_data; r0 = lcd_rs; end
                if (n_pulse == 1) begin d1 = lcd_data; r1 = lcd_rs; end
                n_pulse++;
            end
            prev_e = lcd_e;
            if (writeDone) begin
                lat = k;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        #3 resetFSM = 1'b0;
        #1;
        n_vec++;
        if ({lcd_e, lcd_rs, lcd_rw, initDone, writeDone} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got e/rs/rw/init/done=%b required 00000",
                     {lcd_e, lcd_rs, lcd_rw, initDone, writeDone});
        end
        n_vec++;
        if (lcd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got %h required 00", lcd_data);
        end
        tick();
        tick();
    endtask

    // Releases reset, then checks the bus every clock through the init sequence.
    // writeStart pulses during power-up wait and a command wait must be ignored.
    task automatic test_init(input string tag);
        logic       exp_e;
        logic [7:0] exp_d;
        @(posedge clkFSM);
        #1 resetFSM = 1'b1;
        for (int t = 1; t <= 41; t++) begin
            if (t == 5 || t == 20) begin
                data = 8'h55;
                writeStart = 1'b1;
            end
            tick();
            writeStart = 1'b0;
            exp_e = 1'b0;
            exp_d = 8'h00;
            for (int i = 0; i < 4; i++) begin
                if (t >= INIT_SETUP[i] && t <= INIT_SETUP[i] + 2 + INIT_HOLD[i]) exp_d = INIT_BYTE[i];
                if (t == INIT_SETUP[i] + 1 || t == INIT_SETUP[i] + 2) exp_e = 1'b1;
            end
            n_vec++;
            if (lcd_e !== exp_e || lcd_data !== exp_d || lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin
                n_err++;
                $display("FAIL %s_init_bus t=%0d: got e=%b d=%h rs=%b rw=%b required e=%b d=%h rs=0 rw=0",
                         tag, t, lcd_e, lcd_data, lcd_rs, lcd_rw, exp_e, exp_d);
            end
            n_vec++;
            if (initDone !== 1'b0 || writeDone !== 1'b0) begin
                n_err++;
                $display("FAIL %s_init_flags t=%0d: got init=%b done=%b required 0 0",
                         tag, t, initDone, writeDone);
            end
        end
        tick();
        n_vec++;
        if (initDone !== 1'b1 || lcd_e !== 1'b0) begin
            n_err++;
            $display("FAIL %s_init_done: got init=%b e=%b required init=1 e=0", tag, initDone, lcd_e);
        end
    endtask

    // Single write of 'A', cycle by cycle; a writeStart during the wait must be ignored.
    task automatic test_write();
        logic exp_e;
        logic exp_done;
        data = 8'h41;
        writeStart = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            writeStart = 1'b0;
            if (k == 1) data = 8'h00;
            exp_e    = (k == 2 || k == 3);
            exp_done = (k == 8);
            n_vec++;
            if (lcd_e !== exp_e || writeDone !== exp_done || lcd_rw !== 1'b0) begin
                n_err++;
                $display("FAIL write_strobe k=%0d: got e=%b done=%b rw=%b required e=%b done=%b rw=0",
                         k, lcd_e, writeDone, lcd_rw, exp_e, exp_done);
            end
            if (k <= 7) begin
                n_vec++;
                if (lcd_data !== 8'h41 || lcd_rs !== 1'b1) begin
                    n_err++;
                    $display("FAIL write_bus k=%0d: got d=%h rs=%b required d=41 rs=1", k, lcd_data, lcd_rs);
                end
            end
            if (k == 4) begin
                data = 8'h5A;
                writeStart = 1'b1;
            end
        end
    endtask

    // Writes 2..33 since reset: 16th adds 0xC0, 32nd adds 0x80, 33rd is plain again.
    task automatic test_wrap();
        int         lat, np;
        logic [7:0] d0, d1;
        logic       r0, r1;
        int         exp_lat, exp_np;
        logic [7:0] exp_addr;
        for (int n = 2; n <= 33; n++) begin
            do_write(8'(8'h20 + n), lat, np, d0, r0, d1, r1);
            exp_lat  = (n == 16 || n == 32) ? 15 : 8;
            exp_np   = (n == 16 || n == 32) ? 2 : 1;
            exp_addr = (n == 16) ? 8'hC0 : 8'h80;
            n_vec++;
            if (lat !== exp_lat || np !== exp_np) begin
                n_err++;
                $display("FAIL wrap_timing n=%0d: got lat=%0d pulses=%0d required lat=%0d pulses=%0d",
                         n, lat, np, exp_lat, exp_np);
            end
            n_vec++;
            if (d0 !== 8'(8'h20 + n) || r0 !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_char n=%0d: got d=%h rs=%b required d=%h rs=1", n, d0, r0, 8'(8'h20 + n));
            end
            if (exp_np == 2) begin
                n_vec++;
                if (d1 !== exp_addr || r1 !== 1'b0) begin
                    n_err++;
                    $display("FAIL wrap_addr n=%0d: got d=%h rs=%b required d=%h rs=0", n, d1, r1, exp_addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int         lat, np;
        logic [7:0] d0, d1;
        logic       r0, r1;
        data = 8'h33;
        writeStart = 1'b1;
        tick();
        writeStart = 1'b0;
        tick();
        n_vec++;
        if (lcd_e !== 1'b1) begin
            n_err++;
            $display("FAIL midwr_enable: got e=%b required 1", lcd_e);
        end
        resetFSM = 1'b0;
        #1;
        n_vec++;
        if (lcd_e !== 1'b0 || initDone !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 8'h00) begin
            n_err++;
            $display("FAIL midwr_abort: got e=%b init=%b rs=%b d=%h required 0 0 0 00",
                     lcd_e, initDone, lcd_rs, lcd_data);
        end
        test_init("re");
        do_write(8'h7E, lat, np, d0, r0, d1, r1);
        n_vec++;
        if (lat !== 8 || np !== 1 || d0 !== 8'h7E || r0 !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_write: got lat=%0d pulses=%0d d=%h rs=%b required 8 1 7e 1",
                     lat, np, d0, r0);
        end
    endtask

    initial begin
        test_reset();
        test_init("pwr");
        test_write();
        test_wrap();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
